// File: rtl/adc_burst_sequencer.sv
// Paces ADC conversions at a fixed interval and stores each result in the burst buffer.
// Ports: start/abort control, ADC request/done/data, buffer write port, and busy/done/overrun/count status.
module adc_burst_sequencer #(
  parameter int MaxADCBurstReadings = 13,
  parameter int ADCDataWidth        = 16,
  parameter int IntervalWidth       = 16
) (
  input  logic                                       clk_i,
  input  logic                                       reset_ni,
  input  logic                                       start_i,
  input  logic                                       abort_i,
  input  logic [$clog2(MaxADCBurstReadings+1)-1:0]   burst_log2_i,
  input  logic [IntervalWidth-1:0]                   interval_i,
  output logic                                       adc_start_o,
  input  logic                                       adc_done_i,
  input  logic [ADCDataWidth-1:0]                    adc_data_i,
  output logic                                       buf_we_o,
  output logic [MaxADCBurstReadings-1:0]             buf_addr_o,
  output logic [ADCDataWidth-1:0]                    buf_data_o,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       overrun_o,
  output logic [MaxADCBurstReadings:0]               count_o
);

  localparam int M  = MaxADCBurstReadings;
  localparam int BW = $clog2(MaxADCBurstReadings+1);
  localparam int CW = MaxADCBurstReadings + 1;
  localparam int IW = IntervalWidth;
  localparam int DW = ADCDataWidth;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    WAIT_DONE,
    WRITE,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] n_q, n_d;
  logic [IW-1:0] ivl_q, ivl_d;
  logic [IW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] data_q, data_d;

  logic          tick;
  logic [CW-1:0] cnt_inc;
  logic [BW-1:0] log2_clamp;
  logic [IW-1:0] ivl_new;

  assign tick    = busy_q && (tmr_q == '0);
  assign cnt_inc = cnt_q + CW'(1);

  assign log2_clamp = (burst_log2_i > BW'(M)) ? BW'(M) : burst_log2_i;
  // Timer holds I-1; an interval of 0 is treated as 1
  assign ivl_new = (interval_i == '0) ? '0 : interval_i - IW'(1);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ovr_d       = ovr_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    ivl_d       = ivl_q;
    tmr_d       = tmr_q;
    data_d      = data_q;
    adc_start_o = 1'b0;
    buf_we_o    = 1'b0;

    if (busy_q) begin
      if (tmr_q == '0) tmr_d = ivl_q;
      else             tmr_d = tmr_q - IW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d = WAIT_TICK;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ovr_d   = 1'b0;
          cnt_d   = '0;
          pend_d  = 1'b1;
          n_d     = CW'(1) << log2_clamp;
          ivl_d   = ivl_new;
          tmr_d   = ivl_new;
        end
      end
      WAIT_TICK: begin
        if (pend_q || tick) begin
          adc_start_o = 1'b1;
          pend_d      = 1'b0;
          tmr_d       = ivl_q;
          state_d     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tick) begin
          ovr_d  = 1'b1;
          pend_d = 1'b1;
        end
        if (adc_done_i) begin
          data_d  = adc_data_i;
          state_d = WRITE;
        end
      end
      WRITE: begin
        buf_we_o = 1'b1;
        cnt_d    = cnt_inc;
        if (tick) begin
          ovr_d  = 1'b1;
          pend_d = 1'b1;
        end
        state_d = (cnt_inc == n_q) ? FINISH : WAIT_TICK;
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides anything scheduled this cycle
    if (abort_i && state_q != IDLE) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      done_d      = done_q;
      ovr_d       = ovr_q;
      pend_d      = 1'b0;
      cnt_d       = cnt_q;
      data_d      = data_q;
      adc_start_o = 1'b0;
      buf_we_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      n_q     <= '0;
      ivl_q   <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ivl_q   <= ivl_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
    end
  end

  assign buf_addr_o = cnt_q[M-1:0];
  assign buf_data_o = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overrun_o  = ovr_q;
  assign count_o    = cnt_q;

endmodule

// File: tb/tb_adc_burst_sequencer.sv
// Directed bench for adc_burst_sequencer.
// Models an ADC with programmable latency and logs starts and buffer writes.
module tb_adc_burst_sequencer;

  localparam int M  = 13;
  localparam int DW = 16;
  localparam int IW = 16;
  localparam int BW = $clog2(M+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [BW-1:0] burst_log2_i = '0;
  logic [IW-1:0] interval_i = '0;
  logic          adc_start_o;
  logic          adc_done_i;
  logic [DW-1:0] adc_data_i;
  logic          buf_we_o;
  logic [M-1:0]  buf_addr_o;
  logic [DW-1:0] buf_data_o;
  logic          busy_o;
  logic          done_o;
  logic          overrun_o;
  logic [M:0]    count_o;

  adc_burst_sequencer #(
    .MaxADCBurstReadings(M),
    .ADCDataWidth(DW),
    .IntervalWidth(IW)
  ) dut (
    .clk_i(clk),
    .reset_ni(rst_n),
    .start_i(start_i),
    .abort_i(abort_i),
    .burst_log2_i(burst_log2_i),
    .interval_i(interval_i),
    .adc_start_o(adc_start_o),
    .adc_done_i(adc_done_i),
    .adc_data_i(adc_data_i),
    .buf_we_o(buf_we_o),
    .buf_addr_o(buf_addr_o),
    .buf_data_o(buf_data_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .overrun_o(overrun_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  int t0 = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int st_q[$];
  int wr_t[$];
  int wr_a[$];
  int wr_d[$];

  always @(negedge clk) begin
    if (adc_start_o) st_q.push_back(cyc);
    if (buf_we_o) begin
      wr_t.push_back(cyc);
      wr_a.push_back(int'(buf_addr_o));
      wr_d.push_back(int'(buf_data_o));
    end
  end

  int lat = 3;
  int k = 0;

  initial begin
    adc_done_i = 1'b0;
    adc_data_i = '0;
    forever begin
      @(negedge clk);
      if (adc_start_o) begin
        repeat (lat) @(posedge clk);
        #1;
        adc_done_i = 1'b1;
        adc_data_i = DW'(32'h1000 + k);
        k++;
        @(posedge clk);
        #1;
        adc_done_i = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    st_q.delete();
    wr_t.delete();
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic go(input int b, input int iv, input int l);
    lat = l;
    k = 0;
    clear_logs();
    @(posedge clk);
    #1;
    burst_log2_i = BW'(b);
    interval_i = IW'(iv);
    start_i = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int c = 0;
    while (!done_o && c < maxc) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("done_timeout", {31'd0, done_o}, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_seq(input string tag, input int n);
    check({tag, "_nwr"}, wr_a.size(), n);
    for (int i = 0; i < n && i < wr_a.size(); i++) begin
      check({tag, "_addr"}, wr_a[i], i);
      check({tag, "_data"}, wr_d[i], 32'h1000 + i);
    end
  endtask

  initial begin
    #3;
    check("rst_start", {31'd0, adc_start_o}, 0);
    check("rst_we", {31'd0, buf_we_o}, 0);
    check("rst_addr", buf_addr_o, 0);
    check("rst_data", buf_data_o, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_done", {31'd0, done_o}, 0);
    check("rst_ovr", {31'd0, overrun_o}, 0);
    check("rst_cnt", count_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic burst: 4 samples, interval 10, latency 3
    go(2, 10, 3);
    wait_done(200);
    check("t1_nst", st_q.size(), 4);
    for (int i = 0; i < 4 && i < st_q.size(); i++)
      check("t1_st_time", st_q[i] - t0, 1 + 10 * i);
    for (int i = 0; i < 4 && i < wr_t.size() && i < st_q.size(); i++)
      check("t1_wr_lat", wr_t[i] - st_q[i], 4);
    check_seq("t1", 4);
    check("t1_cnt", count_o, 4);
    check("t1_ovr", {31'd0, overrun_o}, 0);
    check("t1_busy", {31'd0, busy_o}, 0);

    // Overrun: interval 4 shorter than latency 6
    go(3, 4, 6);
    wait_done(400);
    check("t2_ovr", {31'd0, overrun_o}, 1);
    check("t2_nst", st_q.size(), 8);
    for (int i = 1; i < 8 && i < st_q.size() && i <= wr_t.size(); i++)
      check("t2_gap", st_q[i] - wr_t[i-1], 1);
    check_seq("t2", 8);
    check("t2_cnt", count_o, 8);

    // Abort while waiting on the third conversion
    go(3, 10, 3);
    repeat (21) @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t3_nwr", wr_a.size(), 2);
    check("t3_nst", st_q.size(), 3);
    check("t3_busy", {31'd0, busy_o}, 0);
    check("t3_done", {31'd0, done_o}, 0);
    check("t3_cnt", count_o, 2);

    // start and abort together in IDLE
    clear_logs();
    @(posedge clk);
    #1;
    abort_i = 1'b1;
    pulse_start();
    abort_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_nst", st_q.size(), 0);
    check("t4_busy", {31'd0, busy_o}, 0);
    check("t4_cnt", count_o, 2);

    // Repeated start during a burst is ignored
    go(2, 10, 3);
    repeat (5) @(posedge clk);
    #1;
    pulse_start();
    repeat (8) @(posedge clk);
    #1;
    pulse_start();
    wait_done(200);
    check("t5_nst", st_q.size(), 4);
    if (st_q.size() == 4) check("t5_last_st", st_q[3] - t0, 31);
    check_seq("t5", 4);
    check("t5_cnt", count_o, 4);

    // interval 0 behaves as 1
    go(1, 0, 1);
    wait_done(100);
    check("t6_nst", st_q.size(), 2);
    if (st_q.size() == 2) check("t6_st1", st_q[1] - t0, 4);
    check("t6_ovr", {31'd0, overrun_o}, 1);
    check_seq("t6", 2);

    // Burst length clamps to 2^13
    begin
      int err = 0;
      go(15, 0, 1);
      wait_done(40000);
      check("t7_nwr", wr_a.size(), 8192);
      for (int i = 0; i < wr_a.size(); i++)
        if (wr_a[i] != i || wr_d[i] != ((32'h1000 + i) & 32'hFFFF)) err++;
      check("t7_seq_err", err, 0);
      check("t7_cnt", count_o, 8192);
      check("t7_busy", {31'd0, busy_o}, 0);
    end

    // Asynchronous reset mid-burst
    go(2, 10, 3);
    repeat (10) @(posedge clk);
    #1;
    check("t8_pre_start", {31'd0, adc_start_o}, 1);
    check("t8_pre_busy", {31'd0, busy_o}, 1);
    check("t8_pre_cnt", count_o, 1);
    rst_n = 1'b0;
    #1;
    check("t8_start", {31'd0, adc_start_o}, 0);
    check("t8_busy", {31'd0, busy_o}, 0);
    check("t8_cnt", count_o, 0);
    check("t8_data", buf_data_o, 0);
    check("t8_addr", buf_addr_o, 0);
    check("t8_we", {31'd0, buf_we_o}, 0);
    check("t8_done", {31'd0, done_o}, 0);
    check("t8_ovr", {31'd0, overrun_o}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    go(2, 10, 3);
    wait_done(200);
    check_seq("t8_post", 4);
    check("t8_post_cnt", count_o, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_burst_sequencer.md
Name: adc_burst_sequencer

Overview:
- Schedules ADC burst captures for the 6502 system.
- Paces conversion starts to the ADC SPI engine at a programmable interval and writes each result into the burst sample buffer at an incrementing address.
- Reports busy, done and overrun status to the CPU register block.
- Sits between the CPU peripheral registers, the ADC SPI engine and the burst buffer RAM, all in the clk_i domain.

Parameters:
- MaxADCBurstReadings, 13: log2 of the maximum burst depth (13 gives 8192 entries); sets the buffer address width.
- ADCDataWidth, 16: width of one ADC result word.
- IntervalWidth, 16: width of the sample-interval field, in clk_i cycles.

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse that starts a burst
- abort_i  in  1  one-cycle pulse that aborts a burst
- burst_log2_i  in  $clog2(MaxADCBurstReadings+1)  burst length is 2^burst_log2_i samples
- interval_i  in  IntervalWidth  clk_i cycles between conversion starts
- adc_start_o  out  1  one-cycle conversion request to the ADC SPI engine
- adc_done_i  in  1  one-cycle pulse: conversion complete
- adc_data_i  in  ADCDataWidth  result, valid while adc_done_i is high
- buf_we_o  out  1  buffer write strobe
- buf_addr_o  out  MaxADCBurstReadings  buffer write address
- buf_data_o  out  ADCDataWidth  buffer write data
- busy_o  out  1  burst in progress
- done_o  out  1  sticky: last burst completed
- overrun_o  out  1  sticky: an interval tick arrived while a conversion was outstanding
- count_o  out  MaxADCBurstReadings+1  samples written in the current or last burst

Behaviour:
- Reset value of every output is 0. The internal state is IDLE.
- Captured on start_i:
  - N = 2^min(burst_log2_i, MaxADCBurstReadings).
  - I = max(interval_i, 1).
  - Both are held for the whole burst.
- States: IDLE, WAIT_TICK, WAIT_DONE, WRITE, FINISH.
- IDLE:
  - On start_i without abort_i: clear done_o, overrun_o and count_o; set busy_o; go to WAIT_TICK with a tick already pending.
  - If start_i and abort_i arrive together, abort wins and the block stays in IDLE.
  - adc_done_i is ignored in IDLE (no write).
- Interval timer:
  - Runs only while busy_o is high.
  - Loaded with I-1 on the cycle adc_start_o is issued; decrements to 0.
  - When it reaches 0 it raises a tick and reloads with I-1.
- WAIT_TICK:
  - When a tick is pending, assert adc_start_o for exactly one cycle, clear the pending tick and go to WAIT_DONE.
  - First adc_start_o occurs on the cycle after start_i.
- WAIT_DONE: on adc_done_i, register adc_data_i and go to WRITE.
- WRITE:
  - Assert buf_we_o for one cycle, with buf_addr_o = count_o[MaxADCBurstReadings-1:0] and buf_data_o = the registered data.
  - Increment count_o.
  - Latency from adc_done_i to buf_we_o is exactly 1 cycle.
  - If the new count_o equals N, go to FINISH; otherwise go to WAIT_TICK.
- Overrun: a tick arriving in WAIT_DONE or WRITE sets overrun_o (sticky) and sets the pending tick. The next adc_start_o then issues on the first WAIT_TICK cycle, i.e. immediately after the write. Ticks never queue deeper than one.
- FINISH: clear busy_o, set done_o and go to IDLE, one cycle after the final buf_we_o.
- abort_i in any non-IDLE state:
  - Go to IDLE next cycle, clear busy_o, suppress any write or start scheduled that cycle.
  - done_o stays 0; count_o holds the samples written so far.
  - A late adc_done_i is ignored.
- start_i while busy_o is high is ignored.
- buf_addr_o wraps naturally only at N = 2^MaxADCBurstReadings. count_o is one bit wider so it can hold N.
- Asserting reset_ni low mid-burst forces IDLE and all outputs to 0 immediately, without waiting for clk_i.

Test Plan:
- burst_log2_i=2, interval_i=10, ADC done 3 cycles after each start with data 0x1000+k:
  - adc_start_o at cycles 1, 11, 21, 31 after start_i.
  - Writes addr 0..3 with data 0x1000..0x1003.
  - done_o=1, count_o=4, overrun_o=0.
- interval_i=4, ADC latency 6 cycles, burst_log2_i=3:
  - overrun_o=1.
  - Each start issues 1 cycle after the previous write.
  - All 8 samples are written in order.
- Abort in WAIT_DONE after 2 samples, then adc_done_i pulses:
  - No further buf_we_o.
  - busy_o=0, done_o=0, count_o=2.
- start_i and abort_i in the same cycle in IDLE → no adc_start_o, busy_o stays 0. start_i repeated during a burst → no effect on count or addresses.
- burst_log2_i=15 with MaxADCBurstReadings=13 → exactly 8192 writes, buf_addr_o 0..8191, count_o=8192. interval_i=0 behaves as 1.
- reset_ni pulsed low mid-burst → all outputs 0 before the next clk_i edge; a fresh start_i afterwards runs a normal burst from addr 0.
